// File: rtl/uart_pkt_parser_pkg.sv
// Shared types and constants for the UART packet parser.
package uart_pkt_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // A one-entry buffer still needs a 1-bit address.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_parser_if.sv
// Byte-in / payload-out stream bundle plus packet status for the parser.
interface uart_pkt_parser_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, pkt_ok, pkt_err, err_code, busy
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, pkt_ok, pkt_err, err_code, busy
    );
endinterface

// File: rtl/uart_pkt_parser_buf.sv
// Payload buffer: simple dual-port RAM, one write port, registered read port.
module pkt_buf_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/uart_pkt_parser.sv
// Frame parser: SOF, LEN, payload, CSUM; verified payload is replayed from a buffer.
module uart_pkt_parser
    import uart_pkt_parser_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SOF            = SOF_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    uart_pkt_parser_if.slave   bus
);
    localparam int            AW        = addr_w(MAX_LEN);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t        state;
    logic [7:0]    len, wr_idx, rd_idx, csum, csum_next, rdata;
    logic [TW-1:0] tmo_cnt;
    logic          accept, drain_adv, timed_out;

    assign accept    = bus.in_valid & bus.in_ready;
    assign drain_adv = bus.out_valid & bus.out_ready;
    assign csum_next = csum + bus.in_data;
    assign timed_out = (state inside {ST_LEN, ST_PAYLOAD, ST_CSUM}) && !accept && (tmo_cnt == TMO_LAST);

    // RAM output is already registered; mask it so idle/reset shows zero.
    assign bus.out_data = bus.out_valid ? rdata : 8'h00;

    // Read address runs one ahead on acceptance so rdata is ready the next cycle;
    // on stall it re-reads the same entry, keeping out_data stable.
    pkt_buf_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (state == ST_PAYLOAD && accept),
        .waddr (wr_idx[AW-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_idx[AW-1:0] + AW'(drain_adv && !bus.out_last)),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            len           <= '0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            csum          <= '0;
            tmo_cnt       <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.pkt_ok    <= 1'b0;
            bus.pkt_err   <= 1'b0;
            bus.err_code  <= ERR_NONE;
            bus.busy      <= 1'b0;
        end else begin
            bus.pkt_ok   <= 1'b0;
            bus.pkt_err  <= 1'b0;
            bus.in_ready <= 1'b1;
            if (accept || state == ST_IDLE || state == ST_DRAIN)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            if (timed_out) begin
                state        <= ST_IDLE;
                bus.busy     <= 1'b0;
                bus.pkt_err  <= 1'b1;
                bus.err_code <= ERR_TIMEOUT;
                tmo_cnt      <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (accept && bus.in_data == SOF) begin
                        state    <= ST_LEN;
                        bus.busy <= 1'b1;
                    end
                    ST_LEN: if (accept) begin
                        if (bus.in_data == 8'd0 || bus.in_data > MAX_LEN_B) begin
                            state        <= ST_IDLE;
                            bus.busy     <= 1'b0;
                            bus.pkt_err  <= 1'b1;
                            bus.err_code <= ERR_LEN;
                        end else begin
                            len    <= bus.in_data;
                            csum   <= bus.in_data;
                            wr_idx <= '0;
                            state  <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: if (accept) begin
                        csum   <= csum_next;
                        wr_idx <= wr_idx + 8'd1;
                        if (wr_idx == len - 8'd1)
                            state <= ST_CSUM;
                    end
                    ST_CSUM: if (accept) begin
                        if (csum_next == 8'd0) begin
                            state         <= ST_DRAIN;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_last  <= (len == 8'd1);
                            rd_idx        <= '0;
                        end else begin
                            state        <= ST_IDLE;
                            bus.busy     <= 1'b0;
                            bus.pkt_err  <= 1'b1;
                            bus.err_code <= ERR_CSUM;
                        end
                    end
                    ST_DRAIN: begin
                        bus.in_ready <= 1'b0;
                        if (drain_adv) begin
                            if (bus.out_last) begin
                                state         <= ST_IDLE;
                                bus.busy      <= 1'b0;
                                bus.in_ready  <= 1'b1;
                                bus.out_valid <= 1'b0;
                                bus.out_last  <= 1'b0;
                                bus.pkt_ok    <= 1'b1;
                                rd_idx        <= '0;
                            end else begin
                                rd_idx       <= rd_idx + 8'd1;
                                bus.out_last <= (rd_idx + 8'd2 == len);
                            end
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench: table of per-cycle vectors plus timeout and reset-in-drain sequences.
module tb_uart_pkt_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_pkt_parser_if bus();

    uart_pkt_parser #(.MAX_LEN(16), .TIMEOUT_CYCLES(50), .SOF(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       irdy;
        logic       ov;
        logic [7:0] od;
        logic       last;
        logic       ok;
        logic       err;
        logic [1:0] code;
        logic       busy;
    } obs_t;

    typedef struct {
        logic [7:0] din;
        logic       vin;
        logic       ordy;
        obs_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t observe();
        return {bus.in_ready, bus.out_valid, bus.out_data, bus.out_last,
                bus.pkt_ok, bus.pkt_err, bus.err_code, bus.busy};
    endfunction

    function automatic void add(logic [7:0] d, logic v, logic r, logic ir, logic ov,
                                logic [7:0] od, logic l, logic ok, logic er,
                                logic [1:0] c, logic b);
        vec_t t;
        t.din  = d;
        t.vin  = v;
        t.ordy = r;
        t.exp  = '{irdy: ir, ov: ov, od: od, last: l, ok: ok, err: er, code: c, busy: b};
        vecs.push_back(t);
    endfunction

    // Input byte row: parser is accepting, nothing on the output side.
    function automatic void add_in(logic [7:0] d, logic [1:0] c, logic b);
        add(d, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, c, b);
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got irdy=%b ov=%b od=%h last=%b ok=%b err=%b code=%0d busy=%b want irdy=%b ov=%b od=%h last=%b ok=%b err=%b code=%0d busy=%b",
                     name, act.irdy, act.ov, act.od, act.last, act.ok, act.err, act.code, act.busy,
                     exp.irdy, exp.ov, exp.od, exp.last, exp.ok, exp.err, exp.code, exp.busy);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.in_data   = vecs[i].din;
            bus.in_valid  = vecs[i].vin;
            bus.out_ready = vecs[i].ordy;
            #1;
            check_obs($sformatf("row%0d", i), observe(), vecs[i].exp);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t idle_obs;
        int   k;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Good frame, sum 03+11+22+33+97 = 0x100
        add_in(8'hA5, 2'd0, 1'b0);
        add_in(8'h03, 2'd0, 1'b1);
        add_in(8'h11, 2'd0, 1'b1);
        add_in(8'h22, 2'd0, 1'b1);
        add_in(8'h33, 2'd0, 1'b1);
        add_in(8'h97, 2'd0, 1'b1);
        add(8'h00, 0, 1, 0, 1, 8'h11, 0, 0, 0, 2'd0, 1);
        add(8'h00, 0, 1, 0, 1, 8'h22, 0, 0, 0, 2'd0, 1);
        add(8'h00, 0, 1, 0, 1, 8'h33, 1, 0, 0, 2'd0, 1);
        add(8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 0, 2'd0, 0);
        // Bad checksum 98
        add_in(8'hA5, 2'd0, 1'b0);
        add_in(8'h03, 2'd0, 1'b1);
        add_in(8'h11, 2'd0, 1'b1);
        add_in(8'h22, 2'd0, 1'b1);
        add_in(8'h33, 2'd0, 1'b1);
        add_in(8'h98, 2'd0, 1'b1);
        add(8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 1, 2'd2, 0);
        // Good frame again, err_code held at 2
        add_in(8'hA5, 2'd2, 1'b0);
        add_in(8'h03, 2'd2, 1'b1);
        add_in(8'h11, 2'd2, 1'b1);
        add_in(8'h22, 2'd2, 1'b1);
        add_in(8'h33, 2'd2, 1'b1);
        add_in(8'h97, 2'd2, 1'b1);
        add(8'h00, 0, 1, 0, 1, 8'h11, 0, 0, 0, 2'd2, 1);
        add(8'h00, 0, 1, 0, 1, 8'h22, 0, 0, 0, 2'd2, 1);
        add(8'h00, 0, 1, 0, 1, 8'h33, 1, 0, 0, 2'd2, 1);
        add(8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 0, 2'd2, 0);
        // Junk then LEN=0
        add_in(8'h00, 2'd2, 1'b0);
        add_in(8'h7F, 2'd2, 1'b0);
        add_in(8'hA5, 2'd2, 1'b0);
        add_in(8'h00, 2'd2, 1'b1);
        add(8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 1, 2'd1, 0);
        // LEN=17 > MAX_LEN
        add_in(8'hA5, 2'd1, 1'b0);
        add_in(8'h11, 2'd1, 1'b1);
        add(8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 1, 2'd1, 0);
        // LEN=1, payload and checksum are both SOF-like bytes: 01+A5+5A = 0x100
        add_in(8'hA5, 2'd1, 1'b0);
        add_in(8'h01, 2'd1, 1'b1);
        add_in(8'hA5, 2'd1, 1'b1);
        add_in(8'h5A, 2'd1, 1'b1);
        add(8'h00, 0, 1, 0, 1, 8'hA5, 1, 0, 0, 2'd1, 1);
        add(8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 0, 2'd1, 0);
        // Stalled drain 1,0,0,1,0,1 with in_valid held high
        add_in(8'hA5, 2'd1, 1'b0);
        add_in(8'h03, 2'd1, 1'b1);
        add_in(8'h11, 2'd1, 1'b1);
        add_in(8'h22, 2'd1, 1'b1);
        add_in(8'h33, 2'd1, 1'b1);
        add_in(8'h97, 2'd1, 1'b1);
        add(8'hA5, 1, 1, 0, 1, 8'h11, 0, 0, 0, 2'd1, 1);
        add(8'hA5, 1, 0, 0, 1, 8'h22, 0, 0, 0, 2'd1, 1);
        add(8'hA5, 1, 0, 0, 1, 8'h22, 0, 0, 0, 2'd1, 1);
        add(8'hA5, 1, 1, 0, 1, 8'h22, 0, 0, 0, 2'd1, 1);
        add(8'hA5, 1, 0, 0, 1, 8'h33, 1, 0, 0, 2'd1, 1);
        add(8'hA5, 1, 1, 0, 1, 8'h33, 1, 0, 0, 2'd1, 1);
        add(8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 0, 2'd1, 0);

        // Reset values and in_ready rising on the first edge after release
        repeat (2) @(posedge clk);
        #1;
        check_obs("reset_state", observe(), '0);
        rst = 1'b0;
        #1;
        check_int("in_ready_before_edge", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        check_int("in_ready_after_edge", int'(bus.in_ready), 1);

        run_rows(0, vecs.size() - 1);

        // Inter-byte timeout after A5 02 11
        bus.out_ready = 1'b1;
        drive_byte(8'hA5);
        drive_byte(8'h02);
        drive_byte(8'h11);
        k = 0;
        while (k < 60 && bus.pkt_err !== 1'b1) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_int("timeout_cycles", k, 50);
        check_int("timeout_code", int'(bus.err_code), 3);
        check_int("timeout_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        check_int("timeout_pulse_end", int'(bus.pkt_err), 0);

        // Reset while the third payload byte is on the output
        drive_byte(8'hA5);
        drive_byte(8'h03);
        drive_byte(8'h11);
        drive_byte(8'h22);
        drive_byte(8'h33);
        drive_byte(8'h97);
        check_int("drain_b0", int'(bus.out_data), 8'h11);
        @(posedge clk);
        #1;
        check_int("drain_b1", int'(bus.out_data), 8'h22);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_obs("mid_drain_reset", observe(), '0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_obs($sformatf("held_reset%0d", c), observe(), '0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle_obs = '0;
        idle_obs.irdy = 1'b1;
        check_obs("post_reset_idle", observe(), idle_obs);
        run_rows(0, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_pkt_parser.md
UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per packet (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clk cycles.
REQ-003 SHALL have parameter SOF, default 8'hA5, start-of-frame byte.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_data  input  8  byte from the upstream RX FIFO read side.
REQ-007 SHALL have port in_valid  input  1  in_data valid (FIFO not empty).
REQ-008 SHALL have port in_ready  output  1  byte accepted when in_valid&in_ready (drives the FIFO read enable).
REQ-009 SHALL have port out_data  output  8  payload byte.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts when out_valid&out_ready.
REQ-012 SHALL have port out_last  output  1  marks the final payload byte of a packet.
REQ-013 SHALL have port pkt_ok  output  1  one-cycle pulse on acceptance of the last payload byte.
REQ-014 SHALL have port pkt_err  output  1  one-cycle pulse on packet rejection.
REQ-015 SHALL have port err_code  output  2  1=bad LEN, 2=checksum, 3=timeout; held until the next pkt_err.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL use the frame format SOF, LEN, LEN payload bytes, CSUM; a frame is valid when (LEN + sum of payload + CSUM) mod 256 == 0.
REQ-018 SHALL implement states IDLE, LEN, PAYLOAD, CSUM and DRAIN.
REQ-019 SHALL drive in_ready=1 in IDLE, LEN, PAYLOAD and CSUM, and in_ready=0 in DRAIN.
REQ-020 IDLE: SHALL discard accepted bytes other than SOF silently; an accepted SOF SHALL move to LEN.
REQ-021 LEN: LEN==0 or LEN>MAX_LEN SHALL pulse pkt_err, set err_code=1 and return to IDLE; otherwise it SHALL store LEN, seed the checksum with LEN and move to PAYLOAD.
REQ-022 PAYLOAD: each accepted byte SHALL be written to the buffer at index 0..LEN-1 and added (8-bit wrap) to the checksum; after byte LEN the state SHALL move to CSUM.
REQ-023 CSUM: on a good sum the state SHALL move to DRAIN; on a bad sum it SHALL pulse pkt_err, set err_code=2, discard the buffer and return to IDLE.
REQ-024 DRAIN: out_valid SHALL rise the cycle after the CSUM byte is accepted and SHALL present buffer bytes in order.
REQ-025 DRAIN: out_data, out_valid and out_last SHALL hold stable while out_valid&!out_ready.
REQ-026 DRAIN: out_last SHALL be high only with index LEN-1; its acceptance SHALL pulse pkt_ok and return the state to IDLE, with out_valid=0 on the next cycle.
REQ-027 SHALL never assert out_valid for a packet that fails checksum or LEN checks.
REQ-028 Timeout counter: SHALL clear on every accepted byte and count cycles in LEN, PAYLOAD and CSUM; on reaching TIMEOUT_CYCLES it SHALL pulse pkt_err, set err_code=3 and return to IDLE; it SHALL not count in IDLE or DRAIN.
REQ-029 An SOF value received inside LEN, PAYLOAD or CSUM SHALL be treated as data, with no resync.
REQ-030 pkt_ok and pkt_err SHALL never be high in the same cycle.

Reset
REQ-031 On rst, the state SHALL go to IDLE and in_ready, out_valid, out_last, pkt_ok, pkt_err and busy SHALL go to 0, err_code to 0 and out_data to 8'h00, with all counters and the checksum cleared.
REQ-032 Reset mid-packet or mid-DRAIN SHALL drop the packet with no pkt_ok or pkt_err pulse; buffer contents need not be cleared.
REQ-033 in_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-034 A shared package SHALL hold the state enum, the err_code constants (ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2, ERR_TIMEOUT=3) and the SOF default.
REQ-035 The payload buffer SHALL be a sub-module pkt_buf_ram: MAX_LEN x 8, one write port, one registered read port, inferred RAM.
REQ-036 Buffer read SHALL be prefetched so DRAIN sustains one byte per cycle while out_ready=1.

Verification
REQ-037 Input A5 03 11 22 33 97 with out_ready=1 -> outputs 11, 22, 33 on consecutive cycles, out_last with 33, one pkt_ok.
REQ-038 Same frame with CSUM=98 -> no out_valid, pkt_err with err_code=2, parser then accepts a good frame.
REQ-039 Input 00 7F A5 00 -> leading bytes ignored, pkt_err with err_code=1; input A5 11 (LEN 17 > 16) -> err_code=1.
REQ-040 Input A5 02 11 then in_valid=0 for TIMEOUT_CYCLES (set to 50) -> pkt_err with err_code=3 at cycle 50, busy=0.
REQ-041 Good 3-byte frame with out_ready toggling 1,0,0,1 -> data held while stalled, in_ready=0 throughout DRAIN, bytes delivered exactly once.
REQ-042 rst asserted after the 2nd payload byte is output -> outputs return to reset values, no pulses, next frame parsed correctly.
